// File: rtl/stream_demux2_pkg.sv
// Shared constants for the stream demultiplexer. The select encoding matches
// the 2:1 select mux so that a producer can drive either block the same way.
package stream_demux2_pkg;

    localparam int unsigned W_DEF     = 8;
    localparam int unsigned CNT_W_DEF = 16;

    localparam logic SEL_OUT0 = 1'b0;
    localparam logic SEL_OUT1 = 1'b1;

endpackage : stream_demux2_pkg

// File: rtl/demux_fifo2.sv
// Two-entry elastic buffer feeding one demux output.
// Ports: clk, rst_n; push/push_data write the tail; pop removes the head.
//        full/valid are registered occupancy flags; head_data is the head entry.
// The head is held in its own register, so the output data comes directly from a flop.
module demux_fifo2 #(
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  logic [W-1:0] push_data,
    input  logic         pop,
    output logic         full,
    output logic         valid,
    output logic [W-1:0] head_data
);

    logic [1:0]   count_q;
    logic [1:0]   count_d;
    logic [W-1:0] tail_q;
    logic         push_ok;
    logic         do_pop;

    // Guard against pushing into a full buffer or popping an empty one.
    assign push_ok = push && (count_q != 2'd2);
    assign do_pop  = pop && (count_q != 2'd0);

    // Next occupancy.
    always_comb begin
        count_d = count_q;
        case ({push_ok, do_pop})
            2'b10:   count_d = count_q + 2'd1;
            2'b01:   count_d = count_q - 2'd1;
            default: count_d = count_q;
        endcase
    end

    // Storage and registered flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q   <= 2'd0;
            full      <= 1'b0;
            valid     <= 1'b0;
            head_data <= '0;
            tail_q    <= '0;
        end else begin
            count_q <= count_d;
            full    <= (count_d == 2'd2);
            valid   <= (count_d != 2'd0);
            // Incoming word goes straight to the head when the head slot
            // is empty or is being vacated this cycle.
            if (push_ok && ((count_q == 2'd0) || ((count_q == 2'd1) && do_pop))) begin
                head_data <= push_data;
            end else if (do_pop && (count_q == 2'd2)) begin
                head_data <= tail_q;
            end
            if (push_ok && (count_q == 2'd1) && !do_pop) begin
                tail_q <= push_data;
            end
        end
    end

endmodule : demux_fifo2

// File: rtl/stream_demux2.sv
// 1-to-2 valid/ready stream demultiplexer with a 2-deep buffer per output.
// Ports: clk, rst_n; in_valid/in_ready/in_data input stream; in_sel explicit
//        destination (used when rr_en=0); rr_en selects round-robin routing;
//        out0_*/out1_* output streams; cnt0/cnt1 saturating delivery counters.
// in_ready is combinational from registered state plus in_sel/rr_en only.
module stream_demux2
    import stream_demux2_pkg::*;
#(
    parameter int unsigned W     = W_DEF,
    parameter int unsigned CNT_W = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [W-1:0]     in_data,
    input  logic             in_sel,
    input  logic             rr_en,
    output logic             out0_valid,
    input  logic             out0_ready,
    output logic [W-1:0]     out0_data,
    output logic             out1_valid,
    input  logic             out1_ready,
    output logic [W-1:0]     out1_data,
    output logic [CNT_W-1:0] cnt0,
    output logic [CNT_W-1:0] cnt1
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic rr_ptr;
    logic tgt_c;
    logic full0;
    logic full1;
    logic accept_c;
    logic push0_c;
    logic push1_c;
    logic pop0_c;
    logic pop1_c;

    // Destination decode; a full target stalls the input even if the other buffer has room.
    assign tgt_c    = rr_en ? rr_ptr : in_sel;
    assign in_ready = (tgt_c == SEL_OUT1) ? !full1 : !full0;
    assign accept_c = in_valid && in_ready;
    assign push0_c  = accept_c && (tgt_c == SEL_OUT0);
    assign push1_c  = accept_c && (tgt_c == SEL_OUT1);
    assign pop0_c   = out0_valid && out0_ready;
    assign pop1_c   = out1_valid && out1_ready;

    demux_fifo2 #(.W(W)) u_fifo0 (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push0_c),
        .push_data (in_data),
        .pop       (out0_ready),
        .full      (full0),
        .valid     (out0_valid),
        .head_data (out0_data)
    );

    demux_fifo2 #(.W(W)) u_fifo1 (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push1_c),
        .push_data (in_data),
        .pop       (out1_ready),
        .full      (full1),
        .valid     (out1_valid),
        .head_data (out1_data)
    );

    // Round-robin pointer advances only on accepts made in round-robin mode.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr <= SEL_OUT0;
        end else if (accept_c && rr_en) begin
            rr_ptr <= !rr_ptr;
        end
    end

    // Saturating delivery counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt0 <= '0;
            cnt1 <= '0;
        end else begin
            if (pop0_c && (cnt0 != CNT_MAX)) begin
                cnt0 <= cnt0 + CNT_W'(1);
            end
            if (pop1_c && (cnt1 != CNT_MAX)) begin
                cnt1 <= cnt1 + CNT_W'(1);
            end
        end
    end

endmodule : stream_demux2

// File: tb/tb_stream_demux2.sv
// Directed bench for stream_demux2 with a queue-based reference model.
module tb_stream_demux2;

    localparam int unsigned W    = 8;
    localparam int unsigned CW   = 4;
    localparam int          MAXC = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  in_data;
    logic          in_sel;
    logic          rr_en;
    logic          out0_valid;
    logic          out0_ready;
    logic [W-1:0]  out0_data;
    logic          out1_valid;
    logic          out1_ready;
    logic [W-1:0]  out1_data;
    logic [CW-1:0] cnt0;
    logic [CW-1:0] cnt1;

    always #5 clk = ~clk;

    stream_demux2 #(.W(W), .CNT_W(CW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .in_sel     (in_sel),
        .rr_en      (rr_en),
        .out0_valid (out0_valid),
        .out0_ready (out0_ready),
        .out0_data  (out0_data),
        .out1_valid (out1_valid),
        .out1_ready (out1_ready),
        .out1_data  (out1_data),
        .cnt0       (cnt0),
        .cnt1       (cnt1)
    );

    int n_vec = 0;
    int n_err = 0;
    bit chk_en = 1'b0;

    // Reference model: one FIFO queue per output, a pointer bit, two counters.
    logic [W-1:0] q0[$];
    logic [W-1:0] q1[$];
    bit           m_rr;
    int           m_cnt0;
    int           m_cnt1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit m_tgt();
        return rr_en ? m_rr : in_sel;
    endfunction

    function automatic bit m_ready();
        return m_tgt() ? (q1.size() < 2) : (q0.size() < 2);
    endfunction

    // Per-cycle comparison against the model, sampled on the falling edge.
    always @(negedge clk) begin
        if (chk_en) begin
            chk("in_ready", 32'(in_ready), 32'(m_ready()));
            chk("out0_valid", 32'(out0_valid), 32'(q0.size() != 0));
            chk("out1_valid", 32'(out1_valid), 32'(q1.size() != 0));
            if (q0.size() != 0) chk("out0_data", 32'(out0_data), 32'(q0[0]));
            if (q1.size() != 0) chk("out1_data", 32'(out1_data), 32'(q1[0]));
            chk("cnt0", 32'(cnt0), 32'(m_cnt0));
            chk("cnt1", 32'(cnt1), 32'(m_cnt1));
        end
    end

    // Advance one clock, updating the model from the inputs seen at the edge.
    task automatic tick();
        bit t;
        bit acc;
        bit p0;
        bit p1;
        @(posedge clk);
        if (rst_n) begin
            t   = m_tgt();
            acc = in_valid && m_ready();
            p0  = out0_ready && (q0.size() != 0);
            p1  = out1_ready && (q1.size() != 0);
            if (p0) begin
                void'(q0.pop_front());
                if (m_cnt0 < MAXC) m_cnt0++;
            end
            if (p1) begin
                void'(q1.pop_front());
                if (m_cnt1 < MAXC) m_cnt1++;
            end
            if (acc) begin
                if (t) q1.push_back(in_data);
                else   q0.push_back(in_data);
                if (rr_en) m_rr = ~m_rr;
            end
        end
        #1;
    endtask

    task automatic drive(input logic v, input logic s, input logic rr,
                         input logic [W-1:0] d, input logic r0, input logic r1);
        in_valid   = v;
        in_sel     = s;
        rr_en      = rr;
        in_data    = d;
        out0_ready = r0;
        out1_ready = r1;
    endtask

    // Hold the current word until it is accepted, bounded.
    task automatic wait_accept(input string name);
        bit done;
        done = 1'b0;
        for (int k = 0; k < 8 && !done; k++) begin
            done = in_ready;
            tick();
        end
        if (!done) chk({name, " accept timeout"}, 32'd0, 32'd1);
    endtask

    initial begin
        drive(1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1);
        m_rr = 1'b0; m_cnt0 = 0; m_cnt1 = 0;

        // Reset values
        #2;
        chk("rst in_ready", 32'(in_ready), 32'd1);
        chk("rst out0_valid", 32'(out0_valid), 32'd0);
        chk("rst out1_valid", 32'(out1_valid), 32'd0);
        chk("rst out0_data", 32'(out0_data), 32'd0);
        chk("rst out1_data", 32'(out1_data), 32'd0);
        chk("rst cnt0", 32'(cnt0), 32'd0);
        chk("rst cnt1", 32'(cnt1), 32'd0);
        #5 rst_n = 1'b1;
        chk_en = 1'b1;
        tick();

        // Single word to out0
        drive(1'b1, 1'b0, 1'b0, 8'hA5, 1'b1, 1'b1);
        tick();
        chk("s1 out0_valid", 32'(out0_valid), 32'd1);
        chk("s1 out0_data", 32'(out0_data), 32'hA5);
        chk("s1 out1_valid", 32'(out1_valid), 32'd0);
        in_valid = 1'b0;
        tick();
        chk("s1 cnt0", 32'(cnt0), 32'd1);

        // Round-robin 01..04
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 1'b0, 1'b1, 8'(i + 1), 1'b1, 1'b1);
            tick();
            if (i % 2 == 0) chk("rr out0_data", 32'(out0_data), 32'(i + 1));
            else            chk("rr out1_data", 32'(out1_data), 32'(i + 1));
        end
        in_valid = 1'b0;
        tick();
        chk("rr cnt0", 32'(cnt0), 32'd3);
        chk("rr cnt1", 32'(cnt1), 32'd2);

        // Pointer survives rr_en toggling
        drive(1'b1, 1'b0, 1'b1, 8'h05, 1'b1, 1'b1); tick();
        drive(1'b1, 1'b0, 1'b0, 8'h06, 1'b1, 1'b1); tick();
        chk("hold out0_data", 32'(out0_data), 32'h06);
        drive(1'b1, 1'b0, 1'b1, 8'h07, 1'b1, 1'b1); tick();
        chk("hold out1_data", 32'(out1_data), 32'h07);
        in_valid = 1'b0;
        tick();

        // out1 stall with 10,11,12
        drive(1'b1, 1'b1, 1'b0, 8'h10, 1'b1, 1'b0); tick();
        drive(1'b1, 1'b1, 1'b0, 8'h11, 1'b1, 1'b0); tick();
        drive(1'b1, 1'b1, 1'b0, 8'h12, 1'b1, 1'b0);
        #1;
        chk("stall in_ready", 32'(in_ready), 32'd0);
        chk("stall out1_data", 32'(out1_data), 32'h10);
        tick(); tick();
        chk("stall hold data", 32'(out1_data), 32'h10);
        out1_ready = 1'b1;
        tick();
        chk("drain 11", 32'(out1_data), 32'h11);
        tick();
        chk("drain 12", 32'(out1_data), 32'h12);
        in_valid = 1'b0;
        tick();
        chk("drain cnt1", 32'(cnt1), 32'd6);

        // Head-of-line blocking
        drive(1'b1, 1'b1, 1'b0, 8'h1E, 1'b1, 1'b0); tick();
        drive(1'b1, 1'b1, 1'b0, 8'h1F, 1'b1, 1'b0); tick();
        drive(1'b1, 1'b1, 1'b0, 8'h20, 1'b1, 1'b0);
        tick(); tick(); tick();
        chk("hol in_ready", 32'(in_ready), 32'd0);
        chk("hol out0_valid", 32'(out0_valid), 32'd0);
        out1_ready = 1'b1;
        wait_accept("w20");
        chk("hol out0 empty", 32'(out0_valid), 32'd0);
        drive(1'b1, 1'b0, 1'b0, 8'h21, 1'b1, 1'b1);
        wait_accept("w21");
        chk("hol out0_data", 32'(out0_data), 32'h21);
        in_valid = 1'b0;
        tick(); tick();

        // Push and pop together at count 1
        drive(1'b1, 1'b0, 1'b0, 8'h30, 1'b1, 1'b1); tick();
        chk("pp out0_data 30", 32'(out0_data), 32'h30);
        drive(1'b1, 1'b0, 1'b0, 8'h31, 1'b1, 1'b1); tick();
        chk("pp out0_valid", 32'(out0_valid), 32'd1);
        chk("pp out0_data 31", 32'(out0_data), 32'h31);
        in_valid = 1'b0;
        tick();

        // Counter saturation
        for (int i = 0; i < 10; i++) begin
            drive(1'b1, 1'b0, 1'b0, 8'(8'h40 + i), 1'b1, 1'b1);
            tick();
        end
        in_valid = 1'b0;
        tick(); tick();
        chk("sat cnt0", 32'(cnt0), 32'(MAXC));
        chk("sat cnt1", 32'(cnt1), 32'd9);

        // Asynchronous reset with both buffers full
        drive(1'b1, 1'b0, 1'b0, 8'h50, 1'b0, 1'b0); tick();
        drive(1'b1, 1'b0, 1'b0, 8'h51, 1'b0, 1'b0); tick();
        drive(1'b1, 1'b1, 1'b0, 8'h52, 1'b0, 1'b0); tick();
        drive(1'b1, 1'b1, 1'b0, 8'h53, 1'b0, 1'b0); tick();
        in_valid = 1'b0;
        chk("pre-rst out0_valid", 32'(out0_valid), 32'd1);
        chk("pre-rst out1_valid", 32'(out1_valid), 32'd1);
        rst_n = 1'b0;
        q0.delete(); q1.delete();
        m_rr = 1'b0; m_cnt0 = 0; m_cnt1 = 0;
        #1;
        chk("arst out0_valid", 32'(out0_valid), 32'd0);
        chk("arst out1_valid", 32'(out1_valid), 32'd0);
        chk("arst cnt0", 32'(cnt0), 32'd0);
        chk("arst cnt1", 32'(cnt1), 32'd0);
        #5 rst_n = 1'b1;
        out0_ready = 1'b1; out1_ready = 1'b1;
        tick();
        chk("post-rst in_ready", 32'(in_ready), 32'd1);

        // Pointer restarts at out0
        drive(1'b1, 1'b1, 1'b1, 8'h60, 1'b1, 1'b1); tick();
        chk("post-rst rr out0", 32'(out0_data), 32'h60);
        chk("post-rst rr out1_valid", 32'(out1_valid), 32'd0);
        in_valid = 1'b0;
        tick(); tick();

        chk_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule : tb_stream_demux2
